hardtanh_pipe: RTL and testbench
================================

HARDTANH_PIPE -- requirements
Module: hardtanh_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, lane width in bits, signed two's complement fixed-point.
REQ-002 SHALL have parameter FRAC_W, default 8, fractional bits; informational only, with no effect on the compare logic.
REQ-003 SHALL have parameter LANES, default 4, number of elements processed per beat.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, input beat valid.
REQ-007 SHALL have port ready_in, output, 1, block accepts the beat this cycle.
REQ-008 SHALL have port input_data, input, LANES*DATA_W, with lane i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port min_val, input, DATA_W, lower clip bound, signed.
REQ-010 SHALL have port max_val, input, DATA_W, upper clip bound, signed.
REQ-011 SHALL have port valid_out, output, 1, output beat valid.
REQ-012 SHALL have port ready_out, input, 1, downstream accepts the beat.
REQ-013 SHALL have port output_data, output, LANES*DATA_W, clipped lanes, packed as input_data.
REQ-014 SHALL have port clr_count, input, 1, synchronous clear of clip_count.
REQ-015 SHALL have port clip_count, output, 32, count of clipped elements.

Function
REQ-016 SHALL compute each lane as out = min(max(x, min_val), max_val), using signed compares.
REQ-017 SHALL sample min_val and max_val together with each accepted beat; the bounds travel with that beat, so a bound change mid-stream affects only beats accepted afterwards.
REQ-018 SHALL output max_val on every lane when min_val > max_val, as a consequence of the fixed evaluation order.
REQ-019 SHALL transfer a beat when the valid and ready of the same interface are both high in the same cycle.
REQ-020 SHALL be a 2-stage pipeline:
- S1 registers the data and bounds.
- S2 registers the clipped result.
REQ-021 SHALL assert valid_out exactly 2 cycles after acceptance when there is no stall, and sustain 1 beat/cycle throughput.
REQ-022 SHALL hold output_data and valid_out stable while valid_out=1 and ready_out=0.
REQ-023 SHALL drive ready_in = !s1_valid || !s2_valid || ready_out, so that no beat is dropped, duplicated or reordered.
REQ-024 SHALL accept a new beat in the same cycle that one is released when the pipeline is full and ready_out=1.
REQ-025 SHALL count a lane as clipped only when x < min_val or x > max_val; a value equal to a bound is not clipped.
REQ-026 SHALL increment clip_count, on each output transfer, by the number of clipped lanes in that beat.
REQ-027 SHALL saturate clip_count at 0xFFFFFFFF.
REQ-028 SHALL give clr_count priority over a simultaneous increment, so that clip_count becomes 0.

Reset
REQ-029 SHALL, while rst=1, clear s1_valid, s2_valid and valid_out, and drive output_data=0, clip_count=0 and ready_in=0.
REQ-030 SHALL discard in-flight beats on reset mid-operation, and present no stale beat after rst falls.
REQ-031 SHALL assert ready_in=1 in the first cycle after rst falls.

Configuration
REQ-032 SHALL, with HARDTANH_CLIPCNT_EN defined, implement the clip detection and clip_count behaviour of REQ-025 to REQ-028.
REQ-033 SHALL, without HARDTANH_CLIPCNT_EN, keep the clip_count port, tie it to 0, ignore clr_count, and build no counter logic; the data path is unchanged.

Verification
All scenarios use DATA_W=16, LANES=4, min_val=0xFF00 and max_val=0x0100 unless stated.
REQ-034 SHALL cover basic clipping:
- Stimulus: lanes {0x0080, 0x0200, 0xFE00, 0x0100}, ready_out=1.
- Response: 2 cycles later, output {0x0080, 0x0100, 0xFF00, 0x0100} and clip_count=2.
REQ-035 SHALL cover backpressure:
- Stimulus: 8 consecutive beats, values 1..8 on lane 0; ready_out=0 in cycles 3-5.
- Response: all 8 beats out in order; output held constant while stalled; ready_in=0 while S1 and S2 are full.
REQ-036 SHALL cover inverted bounds:
- Stimulus: min_val=0x0100, max_val=0xFF00, any input.
- Response: all lanes 0xFF00.
REQ-037 SHALL cover a bound change mid-stream:
- Stimulus: beat A (0x0200) with max_val=0x0100, then beat B (0x0200) with max_val=0x0300.
- Response: A outputs 0x0100 and B outputs 0x0200.
REQ-038 SHALL cover reset with beats in flight:
- Stimulus: rst=1 for 1 cycle with 2 beats in flight.
- Response: next cycle valid_out=0, output_data=0, clip_count=0; no beat emerges afterwards.
REQ-039 SHALL cover counter clear and the macro-off build:
- Stimulus: clr_count=1 in the same cycle as a transfer of a beat with 3 clipped lanes.
- Response: clip_count=0.
- Macro-off build: clip_count stays 0 for all of REQ-034 to REQ-038.

Source files
------------

// File: rtl/hardtanh_pipe.sv
// hardtanh_pipe: two-stage, multi-lane hardtanh clip with valid/ready handshakes.
//   S1 registers the input lanes together with the clip bounds, so each beat
//   carries its own bounds. S2 registers the clipped lanes and drives the output.
//   Optional feature macro: HARDTANH_CLIPCNT_EN enables per-lane clip detection
//   and the saturating clip_count. Without it, clip_count is tied to zero.
module hardtanh_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [LANES*DATA_W-1:0]   input_data,
    input  logic [DATA_W-1:0]         min_val,
    input  logic [DATA_W-1:0]         max_val,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [LANES*DATA_W-1:0]   output_data,
    input  logic                      clr_count,
    output logic [31:0]               clip_count
);

    localparam int VEC_W = LANES * DATA_W;

    // Max-then-min order: with inverted bounds every lane ends up at hi.
    function automatic logic [DATA_W-1:0] clip_lane(input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] lo,
                                                    input logic [DATA_W-1:0] hi);
        logic [DATA_W-1:0] t;
        t = ($signed(x) < $signed(lo)) ? lo : x;
        return ($signed(t) > $signed(hi)) ? hi : t;
    endfunction

    // FRAC_W only documents the fixed-point format; the compares ignore it.
    logic unused_frac_s;
    assign unused_frac_s = (FRAC_W > DATA_W) ? 1'b1 : 1'b0;

    logic              s1_valid_r;
    logic [VEC_W-1:0]  s1_data_r;
    logic [DATA_W-1:0] s1_min_r;
    logic [DATA_W-1:0] s1_max_r;
    logic              s2_valid_r;
    logic [VEC_W-1:0]  s2_data_r;
    logic [VEC_W-1:0]  clip_data_s;
    logic              s2_ready_s;
    logic              s1_ready_s;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_ready_s  = !s2_valid_r || ready_out;
    assign s1_ready_s  = !s1_valid_r || s2_ready_s;
    assign ready_in    = !rst && s1_ready_s;
    assign valid_out   = s2_valid_r;
    assign output_data = s2_data_r;

    // Clip every S1 lane against the bounds captured with that beat.
    always_comb begin
        clip_data_s = '0;
        for (int i = 0; i < LANES; i++) begin
            clip_data_s[i*DATA_W +: DATA_W] =
                clip_lane(s1_data_r[i*DATA_W +: DATA_W], s1_min_r, s1_max_r);
        end
    end

    // Stage registers: S1 captures accepted beats, S2 captures clipped results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_min_r   <= '0;
            s1_max_r   <= '0;
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
        end else begin
            if (s2_ready_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_data_r <= clip_data_s;
                end
            end
            if (s1_ready_s) begin
                s1_valid_r <= valid_in;
                if (valid_in) begin
                    s1_data_r <= input_data;
                    s1_min_r  <= min_val;
                    s1_max_r  <= max_val;
                end
            end
        end
    end

`ifdef HARDTANH_CLIPCNT_EN
    localparam int NCL_W = $clog2(LANES + 1);

    // A lane sitting exactly on a bound is not counted as clipped.
    function automatic logic is_clipped(input logic [DATA_W-1:0] x,
                                        input logic [DATA_W-1:0] lo,
                                        input logic [DATA_W-1:0] hi);
        return ($signed(x) < $signed(lo)) || ($signed(x) > $signed(hi));
    endfunction

    logic [NCL_W-1:0] nclip_s;
    logic [NCL_W-1:0] s2_nclip_r;
    logic [31:0]      clip_count_r;
    logic [32:0]      sum_s;

    // Count clipped lanes of the beat currently in S1.
    always_comb begin
        nclip_s = '0;
        for (int i = 0; i < LANES; i++) begin
            nclip_s = nclip_s + NCL_W'(is_clipped(s1_data_r[i*DATA_W +: DATA_W],
                                                  s1_min_r, s1_max_r));
        end
    end

    assign sum_s      = {1'b0, clip_count_r} + 33'(s2_nclip_r);
    assign clip_count = clip_count_r;

    // Carry the clip tally alongside S2; add it on output transfer, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_nclip_r   <= '0;
            clip_count_r <= 32'd0;
        end else begin
            if (s2_ready_s && s1_valid_r) begin
                s2_nclip_r <= nclip_s;
            end
            if (clr_count) begin
                clip_count_r <= 32'd0;
            end else if (s2_valid_r && ready_out) begin
                clip_count_r <= sum_s[32] ? 32'hFFFF_FFFF : sum_s[31:0];
            end
        end
    end
`else
    logic unused_clr_s;
    assign unused_clr_s = clr_count;
    assign clip_count   = 32'd0;
`endif

endmodule

// File: tb/tb_hardtanh_pipe.sv
// Self-checking bench for hardtanh_pipe (DATA_W=16, LANES=4).
// Expected beats are queued on acceptance and compared on output transfer;
// a small occupancy model predicts ready_in and valid_out every cycle.
module tb_hardtanh_pipe;
    localparam int DW = 16;
    localparam int L  = 4;
    localparam int W  = DW * L;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          ready_in;
    logic [W-1:0]  input_data;
    logic [DW-1:0] min_val;
    logic [DW-1:0] max_val;
    logic          valid_out;
    logic          ready_out;
    logic [W-1:0]  output_data;
    logic          clr_count;
    logic [31:0]   clip_count;

    hardtanh_pipe #(.DATA_W(16), .FRAC_W(8), .LANES(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .input_data(input_data), .min_val(min_val), .max_val(max_val),
        .valid_out(valid_out), .ready_out(ready_out), .output_data(output_data),
        .clr_count(clr_count), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [W-1:0] exp_q[$];
    int           ncl_q[$];
    logic         m_s1 = 1'b0;
    logic         m_s2 = 1'b0;
    logic [32:0]  exp_cnt = 33'd0;
    logic         stalled = 1'b0;
    logic [W-1:0] held = '0;
    int           accepted;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic [DW-1:0] lo,
                                              input logic [DW-1:0] hi);
        logic [W-1:0]  r;
        logic [DW-1:0] x;
        r = '0;
        for (int i = 0; i < L; i++) begin
            x = d[i*DW +: DW];
            if ($signed(x) < $signed(lo)) x = lo;
            if ($signed(x) > $signed(hi)) x = hi;
            r[i*DW +: DW] = x;
        end
        return r;
    endfunction

    function automatic int ref_nclip(input logic [W-1:0] d, input logic [DW-1:0] lo,
                                     input logic [DW-1:0] hi);
        int n;
        n = 0;
        for (int i = 0; i < L; i++) begin
            if ($signed(d[i*DW +: DW]) < $signed(lo) || $signed(d[i*DW +: DW]) > $signed(hi)) n++;
        end
        return n;
    endfunction

    // One clock cycle: drive, check pre-edge state, update model, step the clock.
    task automatic cycle(input logic vi, input logic [W-1:0] d, input logic ro,
                         input logic clr, input logic r);
        logic s2_rdy;
        logic s1_rdy;
        logic [W-1:0] e;
        int n;
        rst = r; valid_in = vi; input_data = d; ready_out = ro; clr_count = clr;
        #1;
        s2_rdy = !m_s2 || ro;
        s1_rdy = !m_s1 || s2_rdy;
        if (r) begin
            check("ready_in_rst", ready_in, 1'b0);
        end else begin
            check("ready_in", ready_in, s1_rdy);
            check("valid_out", valid_out, m_s2);
            check("clip_count", clip_count, exp_cnt[31:0]);
            if (stalled) check("hold_data", output_data, held);
            n = 0;
            if (m_s2 && ro) begin
                e = exp_q.pop_front();
                n = ncl_q.pop_front();
                check("out_data", output_data, e);
            end
`ifdef HARDTANH_CLIPCNT_EN
            if (clr) exp_cnt = 33'd0;
            else if (m_s2 && ro) begin
                exp_cnt = exp_cnt + 33'(n);
                if (exp_cnt[32]) exp_cnt = 33'h0_FFFF_FFFF;
            end
`endif
            if (s1_rdy && vi) begin
                exp_q.push_back(ref_beat(d, min_val, max_val));
                ncl_q.push_back(ref_nclip(d, min_val, max_val));
                accepted++;
            end
            stalled = m_s2 && !ro;
            held = output_data;
            if (s2_rdy) m_s2 = m_s1;
            if (s1_rdy) m_s1 = vi;
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; stalled = 1'b0; exp_cnt = 33'd0;
            exp_q.delete(); ncl_q.delete();
            check("rst_valid_out", valid_out, 1'b0);
            check("rst_out_data", output_data, '0);
            check("rst_clip_count", clip_count, 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] d;
        int cyc;
        rst = 1'b1; valid_in = 1'b0; input_data = '0; ready_out = 1'b0; clr_count = 1'b0;
        min_val = 16'hFF00; max_val = 16'h0100; accepted = 0;
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Basic clipping, first cycle after reset (ready_in must be 1).
        cycle(1'b1, {16'h0100, 16'hFE00, 16'h0200, 16'h0080}, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: 8 beats on lane 0, ready_out low in cycles 3-5.
        accepted = 0; cyc = 0;
        while (accepted < 8 && cyc < 40) begin
            d = '0;
            d[DW-1:0] = 16'(accepted + 1);
            cycle(1'b1, d, !(cyc >= 3 && cyc <= 5), 1'b0, 1'b0);
            cyc++;
        end
        check("bp_all_accepted", accepted, 8);
        drain(20);

        // Inverted bounds: every lane becomes max_val.
        min_val = 16'h0100; max_val = 16'hFF00;
        cycle(1'b1, {16'h7FFF, 16'h8000, 16'h0000, 16'h0150}, 1'b1, 1'b0, 1'b0);
        drain(10);

        // Bound change between consecutive beats.
        min_val = 16'hFF00; max_val = 16'h0100;
        cycle(1'b1, {4{16'h0200}}, 1'b1, 1'b0, 1'b0);
        max_val = 16'h0300;
        cycle(1'b1, {4{16'h0200}}, 1'b1, 1'b0, 1'b0);
        max_val = 16'h0100;
        drain(10);

        // Reset with two beats in flight; nothing may emerge afterwards.
        cycle(1'b1, {4{16'h0300}}, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, {4{16'h0400}}, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Counter clear on the same cycle as a 3-lane-clipped transfer.
        cycle(1'b1, {16'h0200, 16'hFE00, 16'h7000, 16'h0000}, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Mixed traffic with random backpressure and bounds-straddling data.
        for (int i = 0; i < 40; i++) begin
            d = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
                 16'($urandom_range(16'hFE00, 16'hFFFF)), 16'($urandom_range(0, 16'h0200))};
            cycle(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        drain(20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
